// File: rtl/shift_loader.sv
// Serializes a latched byte into a downstream 8-bit left/right shift register.
// Optional idle gap between bits; supports pause (Hold) and cancel (Abort).
module shift_loader #(
    parameter int unsigned GAP = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Data,
    input  logic       Dir,
    input  logic       Hold,
    input  logic       Abort,
    output logic       Ser_out,
    output logic       RL_out,
    output logic       En_out,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    // Timer is loaded with GAP-1 so that GAP state lasts exactly GAP cycles.
    localparam bit         HAS_GAP    = (GAP != 0);
    localparam logic [3:0] GAP_RELOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [7:0] data_q,  data_d;
    logic       dir_q,   dir_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [3:0] gap_q,   gap_d;
    logic       cur_bit;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            data_q  <= 8'd0;
            dir_q   <= 1'b0;
            cnt_q   <= 3'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    data_d  = Data;
                    dir_d   = Dir;
                    cnt_d   = 3'd0;
                    gap_d   = 4'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (Abort) begin
                    cnt_d   = 3'd0;
                    gap_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (!Hold) begin
                    // A bit leaves on this edge; the last one skips the gap.
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_DONE;
                    end else if (HAS_GAP) begin
                        gap_d   = GAP_RELOAD;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (Abort) begin
                    cnt_d   = 3'd0;
                    gap_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (!Hold) begin
                    if (gap_q == 4'd0) begin
                        state_d = S_SHIFT;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Dir=1 feeds the LSB end, so the MSB must go first to land on top.
    assign cur_bit = dir_q ? data_q[~cnt_q] : data_q[cnt_q];

    assign Ser_out = (state_q == S_SHIFT) && cur_bit;
    assign En_out  = (state_q == S_SHIFT) && !Hold;
    assign RL_out  = dir_q;
    assign Busy    = (state_q == S_SHIFT) || (state_q == S_GAP);
    assign Done    = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_loader.sv
// Directed bench for shift_loader: one GAP=0 and one GAP=2 instance, each
// feeding a model of the downstream 8-bit L/R shift register.
module tb_shift_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start2, hold, abort, dir;
    logic [7:0] data;
    logic       ser0, rl0, en0, busy0, done0;
    logic       ser2, rl2, en2, busy2, done2;
    logic [7:0] word0, word2;
    logic [7:0] seq;
    int         checks = 0;
    int         passed = 0;
    int         b;
    logic       exp_en;

    always #5 clk = ~clk;

    shift_loader #(.GAP(0)) u_g0 (
        .Clk(clk), .Reset(rst), .Start(start0), .Data(data), .Dir(dir),
        .Hold(hold), .Abort(abort), .Ser_out(ser0), .RL_out(rl0),
        .En_out(en0), .Busy(busy0), .Done(done0)
    );

    shift_loader #(.GAP(2)) u_g2 (
        .Clk(clk), .Reset(rst), .Start(start2), .Data(data), .Dir(dir),
        .Hold(hold), .Abort(abort), .Ser_out(ser2), .RL_out(rl2),
        .En_out(en2), .Busy(busy2), .Done(done2)
    );

    // Downstream shifter: RL=0 enters at MSB moving down, RL=1 enters at LSB moving up.
    always @(posedge clk) begin
        if (en0) word0 <= rl0 ? {word0[6:0], ser0} : {ser0, word0[7:1]};
        if (en2) word2 <= rl2 ? {word2[6:0], ser2} : {ser2, word2[7:1]};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Checks 8 consecutive shift cycles on the GAP=0 instance, then Done.
    task automatic expect_bits(input logic [7:0] s, input logic exp_rl, input logic [7:0] exp_word);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                cyc();
                #1;
            end
            chk("en", {7'd0, en0}, 8'd1);
            chk("ser", {7'd0, ser0}, {7'd0, s[7-i]});
            chk("busy", {7'd0, busy0}, 8'd1);
            chk("rl", {7'd0, rl0}, {7'd0, exp_rl});
            chk("done_early", {7'd0, done0}, 8'd0);
        end
        cyc();
        #1;
        chk("done", {7'd0, done0}, 8'd1);
        chk("busy_done", {7'd0, busy0}, 8'd0);
        chk("en_done", {7'd0, en0}, 8'd0);
        chk("ser_done", {7'd0, ser0}, 8'd0);
        chk("word", word0, exp_word);
        start0 = 1'b0;
        cyc();
        #1;
        chk("done_pulse", {7'd0, done0}, 8'd0);
        chk("idle_busy", {7'd0, busy0}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; hold = 1'b0; abort = 1'b0;
        dir = 1'b0; data = 8'h00; word0 = 8'h00; word2 = 8'h00;
        cyc();
        #1;
        chk("rst_ser", {7'd0, ser0}, 8'd0);
        chk("rst_rl", {7'd0, rl0}, 8'd0);
        chk("rst_en", {7'd0, en0}, 8'd0);
        chk("rst_busy", {7'd0, busy0}, 8'd0);
        chk("rst_done", {7'd0, done0}, 8'd0);
        chk("rst_busy2", {7'd0, busy2}, 8'd0);
        cyc();
        rst = 1'b0;

        // A5, Dir=0: Data[0] first
        cyc();
        start0 = 1'b1; data = 8'hA5; dir = 1'b0;
        #1;
        chk("idle_en", {7'd0, en0}, 8'd0);
        cyc();
        start0 = 1'b0;
        #1;
        expect_bits(8'b1010_0101, 1'b0, 8'hA5);

        // 3C, Dir=1, with Start held and Data/Dir changed mid-transfer
        cyc();
        start0 = 1'b1; data = 8'h3C; dir = 1'b1;
        #1;
        cyc();
        data = 8'h00; dir = 1'b0;
        #1;
        expect_bits(8'b0011_1100, 1'b1, 8'h3C);

        // 4D, Dir=0, Hold for 3 cycles after the 4th bit
        cyc();
        start0 = 1'b1; data = 8'h4D; dir = 1'b0;
        #1;
        cyc();
        start0 = 1'b0;
        #1;
        seq = 8'b1011_0010;
        b = 0;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin
                cyc();
                hold = (k >= 4 && k <= 6);
                #1;
            end
            exp_en = !(k >= 4 && k <= 6);
            chk("hold_en", {7'd0, en0}, {7'd0, exp_en});
            chk("hold_ser", {7'd0, ser0}, {7'd0, seq[7-b]});
            chk("hold_busy", {7'd0, busy0}, 8'd1);
            chk("hold_done", {7'd0, done0}, 8'd0);
            if (exp_en) b++;
        end
        cyc();
        #1;
        chk("hold_done_late", {7'd0, done0}, 8'd1);
        chk("hold_word", word0, 8'h4D);

        // F0, Dir=1, Abort (with Hold) after the 5th bit
        cyc();
        start0 = 1'b1; data = 8'hF0; dir = 1'b1;
        #1;
        cyc();
        start0 = 1'b0;
        #1;
        seq = 8'b1111_0000;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                cyc();
                #1;
            end
            chk("ab_en", {7'd0, en0}, 8'd1);
            chk("ab_ser", {7'd0, ser0}, {7'd0, seq[7-k]});
        end
        cyc();
        abort = 1'b1; hold = 1'b1;
        #1;
        chk("ab_busy_pre", {7'd0, busy0}, 8'd1);
        cyc();
        abort = 1'b0; hold = 1'b0;
        #1;
        chk("ab_busy", {7'd0, busy0}, 8'd0);
        chk("ab_done", {7'd0, done0}, 8'd0);
        chk("ab_en_idle", {7'd0, en0}, 8'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk("ab_no_done", {7'd0, done0}, 8'd0);
            chk("ab_idle", {7'd0, busy0}, 8'd0);
        end
        start0 = 1'b1; data = 8'h81; dir = 1'b0;
        cyc();
        start0 = 1'b0;
        #1;
        expect_bits(8'b1000_0001, 1'b0, 8'h81);

        // GAP=2 instance, FF: one pulse every third cycle over 22 busy cycles
        cyc();
        start2 = 1'b1; data = 8'hFF; dir = 1'b0;
        #1;
        cyc();
        start2 = 1'b0;
        #1;
        for (int t = 0; t < 22; t++) begin
            if (t > 0) begin
                cyc();
                #1;
            end
            chk("gap_en", {7'd0, en2}, {7'd0, (t % 3) == 0});
            chk("gap_ser", {7'd0, ser2}, {7'd0, (t % 3) == 0});
            chk("gap_busy", {7'd0, busy2}, 8'd1);
            chk("gap_done", {7'd0, done2}, 8'd0);
        end
        cyc();
        #1;
        chk("gap_done_end", {7'd0, done2}, 8'd1);
        chk("gap_busy_end", {7'd0, busy2}, 8'd0);
        chk("gap_word", word2, 8'hFF);

        // Reset mid-transfer with Start held high
        cyc();
        start0 = 1'b1; data = 8'h96; dir = 1'b1;
        #1;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("mr_ser", {7'd0, ser0}, 8'd0);
        chk("mr_rl", {7'd0, rl0}, 8'd0);
        chk("mr_en", {7'd0, en0}, 8'd0);
        chk("mr_busy", {7'd0, busy0}, 8'd0);
        chk("mr_done", {7'd0, done0}, 8'd0);
        cyc();
        #1;
        chk("mr_hold_busy", {7'd0, busy0}, 8'd0);
        chk("mr_hold_en", {7'd0, en0}, 8'd0);
        cyc();
        rst = 1'b0; data = 8'h2B; dir = 1'b0;
        #1;
        chk("mr_rel_busy", {7'd0, busy0}, 8'd0);
        chk("mr_rel_rl", {7'd0, rl0}, 8'd0);
        cyc();
        start0 = 1'b0;
        #1;
        expect_bits(8'b1101_0100, 1'b0, 8'h2B);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
